pe_array_seq: RTL

//   Job sequencer on the driving side of the PE array: per start command, drives clear and
//   MAC-enable, issues reads to the shared weight/activation buffers and captures the shifted
//   int8 result vector from the PE array into a valid/ready output register. One job = one
//   dot-product pass of length len over all MAC_NUM lanes.

---
 rtl/pe_array_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pe_array_seq.sv
// Job sequencer driving the PE array: feeds buffer reads, sequences clear/MAC-enable,
// waits out the PE pipeline and holds the captured result vector behind a valid/ready register.
module pe_array_seq #(
    parameter int MAC_NUM = 10,
    parameter int BW_ACT  = 8,
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [7:0]                shift_in,
    output logic                      busy,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic                      PE_mac_enable,
    output logic                      PE_clear_acc,
    output logic [7:0]                PE_res_shift_num,
    input  logic [MAC_NUM*BW_ACT-1:0] PE_result_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_NUM*BW_ACT-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [LEN_W-1:0]            cnt_q, cnt_d;
    logic [LEN_W-1:0]            cnt_inc;
    logic [ADDR_W-1:0]           base_q, base_d;
    logic [7:0]                  shift_q, shift_d;
    logic [1:0]                  dcnt_q, dcnt_d;
    logic [MAC_NUM*BW_ACT-1:0]   data_q, data_d;
    logic                        len_zero;
    logic                        feed_last;
    logic                        drain_last;

    assign len_zero   = (len_q == '0);
    assign cnt_inc    = cnt_q + LEN_W'(1);
    assign feed_last  = len_zero || (cnt_inc == len_q);
    assign drain_last = (dcnt_q == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)      state_d = FEED;
            FEED:    if (feed_last)  state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = OUT;
            OUT:     if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Job parameters, step/drain counters and the captured result vector.
    always_comb begin
        len_d   = len_q;
        base_d  = base_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    base_d  = base_addr;
                    shift_d = shift_in;
                    cnt_d   = '0;
                end
            end
            FEED: begin
                cnt_d = cnt_inc;
                // A zero-length job spends its single FEED cycle on the clear, so the
                // drain window starts one step later in the count to keep capture at c+len+3.
                if (feed_last) begin
                    dcnt_d = len_zero ? 2'd1 : 2'd0;
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 2'd1;
                if (drain_last) begin
                    data_d = PE_result_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q   <= '0;
            base_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            data_q  <= '0;
        end else begin
            len_q   <= len_d;
            base_q  <= base_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            data_q  <= data_d;
        end
    end

    // MAC-enable trails the reads by one cycle and stays up one extra cycle to absorb the delayed clear.
    always_comb begin
        busy             = (state_q != IDLE);
        rd_en            = (state_q == FEED) && !len_zero;
        rd_addr          = '0;
        PE_clear_acc     = (state_q == FEED) && (cnt_q == '0);
        PE_mac_enable    = ((state_q == FEED) && (cnt_q != '0)) ||
                           ((state_q == DRAIN) && (dcnt_q < 2'd2));
        PE_res_shift_num = shift_q;
        out_valid        = (state_q == OUT);
        out_data         = data_q;
        if (rd_en) begin
            rd_addr = base_q + ADDR_W'(cnt_q);
        end
    end

endmodule
